// File: rtl/data_mem_arbiter_if.sv
// Requester, response and memory-side bus of the data memory arbiter.
// The arbiter takes the slave view; requesters plus the memory array take the master view.
interface data_mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;

  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          rsp_err;

  logic                          mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  logic [15:0]                   err_count;

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_we, mem_addr, mem_wdata, err_count
  );

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_we, mem_addr, mem_wdata, err_count
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NUM_REQ requesters,
// with address legality filtering, registered responses and an owner lock with timeout.
module data_mem_arbiter #(
  parameter int                    NUM_REQ         = 4,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    ADDR_REAL_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] DATA_BASE       = 32'h1000_0000,
  parameter int                    LOCK_TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst_n,
  data_mem_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST = ADDR_WIDTH'((64'd1 << ADDR_REAL_WIDTH) - 64'd4);
  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e           state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [15:0]           err_cnt_q;

  logic                  accept;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_REQ-1:0]    grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic                  win_we;
  logic                  win_lock;
  logic                  legal;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  // Grant selection: the lock owner only, otherwise first valid after last_grant.
  always_comb begin
    accept    = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        if (bus.req_valid[owner_q]) begin
          accept    = 1'b1;
          grant_idx = owner_q;
        end
      end else begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
          if (!accept && bus.req_valid[cand]) begin
            accept    = 1'b1;
            grant_idx = cand;
          end
        end
      end
      if (accept) grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    win_addr  = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    win_we    = bus.req_we[grant_idx];
    win_lock  = bus.req_lock[grant_idx];
    legal     = (win_addr >= DATA_BASE) &&
                ((win_addr - DATA_BASE) <= MEM_LAST) &&
                (win_addr[1:0] == 2'b00);
  end

  // Illegal or absent accesses park the memory at DATA_BASE with writes disabled.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = DATA_BASE;
    mem_wdata_c = '0;
    if (accept && legal) begin
      mem_we_c    = win_we;
      mem_addr_c  = win_addr;
      mem_wdata_c = win_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    tmo_d        = tmo_q;
    if (accept) begin
      last_grant_d = grant_idx;
      tmo_d        = '0;
      if (win_lock) begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = UNLOCKED;
      end
    end else if (state_q == LOCKED) begin
      // Only reached while the owner is idle; a valid owner always wins over expiry.
      if (tmo_q == TMO_LAST) begin
        state_d      = UNLOCKED;
        tmo_d        = '0;
        last_grant_d = owner_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      tmo_q        <= tmo_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= grant;
      rsp_err_q   <= accept && !legal;
      rsp_rdata_q <= (accept && legal && !win_we) ? bus.mem_rdata : '0;
      if (accept && !legal && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a vector table for arbitration, responses and
// legality, plus hand sequences for lock timeout, counter saturation and async reset.
module tb_data_mem_arbiter;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    string        name;
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [3:0]   lock;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [3:0]   exp_ready;
    logic [3:0]   exp_rsp_valid;
    logic         exp_rsp_err;
    logic [31:0]  exp_rdata;
    logic         exp_mem_we;
    logic [31:0]  exp_mem_addr;
    logic [15:0]  exp_err_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   we_pulses = 0;
  logic [31:0] mem [256];
  vec_t vecs[$];

  data_mem_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_mem_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_REAL_WIDTH(20),
    .DATA_BASE(BASE), .LOCK_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[9:2];
  endfunction

  function automatic logic [31:0] mv(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Behavioural single-port memory: combinational read, write on the rising edge.
  assign bus.mem_rdata = mem[mem_idx(bus.mem_addr)];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[mem_idx(bus.mem_addr)] <= bus.mem_wdata;
      we_pulses++;
    end
  end

  function automatic logic [127:0] pk4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input string n, input logic [3:0] valid, we, lock,
                              input logic [127:0] addr, wdata,
                              input logic [3:0] er, erv, input logic ee,
                              input logic [31:0] erd, input logic emw,
                              input logic [31:0] ema, input logic [15:0] eec);
    vec_t v;
    v.name = n; v.valid = valid; v.we = we; v.lock = lock;
    v.addr = addr; v.wdata = wdata;
    v.exp_ready = er; v.exp_rsp_valid = erv; v.exp_rsp_err = ee;
    v.exp_rdata = erd; v.exp_mem_we = emw; v.exp_mem_addr = ema; v.exp_err_count = eec;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] valid, we, lock, input logic [127:0] addr, wdata);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_lock  = lock;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic apply_stimulus(input vec_t v);
    drive(v.valid, v.we, v.lock, v.addr, v.wdata);
  endtask

  task automatic check_vec(input vec_t v);
    check_output({v.name, ".ready"},     32'(bus.req_ready), 32'(v.exp_ready));
    check_output({v.name, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(v.exp_rsp_valid));
    check_output({v.name, ".rsp_err"},   32'(bus.rsp_err),   32'(v.exp_rsp_err));
    check_output({v.name, ".rsp_rdata"}, bus.rsp_rdata,      v.exp_rdata);
    check_output({v.name, ".mem_we"},    32'(bus.mem_we),    32'(v.exp_mem_we));
    check_output({v.name, ".mem_addr"},  bus.mem_addr,       v.exp_mem_addr);
    check_output({v.name, ".err_count"}, 32'(bus.err_count), 32'(v.exp_err_count));
  endtask

  // One read-only cycle with per-requester valid/lock and a check of the grant.
  task automatic step(input string name, input logic [3:0] valid, lock, input logic [3:0] exp_ready);
    @(negedge clk);
    drive(valid, 4'b0000, lock, pk4(BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC), '0);
    #1;
    check_output(name, 32'(bus.req_ready), 32'(exp_ready));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] a;
    logic [127:0] z;
    int           we_before;

    for (int i = 0; i < 256; i++) mem[i] = mv(i);
    a = pk4(BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC);
    z = '0;
    drive(4'b0, 4'b0, 4'b0, z, z);

    vecs.push_back(mk("rr0", 4'hF, 4'h0, 4'h0, a, z, 4'b0001, 4'b0000, 1'b0, 32'h0,    1'b0, BASE,         16'd0));
    vecs.push_back(mk("rr1", 4'hF, 4'h0, 4'h0, a, z, 4'b0010, 4'b0001, 1'b0, mv(0),    1'b0, BASE + 32'h4, 16'd0));
    vecs.push_back(mk("rr2", 4'hF, 4'h0, 4'h0, a, z, 4'b0100, 4'b0010, 1'b0, mv(1),    1'b0, BASE + 32'h8, 16'd0));
    vecs.push_back(mk("rr3", 4'hF, 4'h0, 4'h0, a, z, 4'b1000, 4'b0100, 1'b0, mv(2),    1'b0, BASE + 32'hC, 16'd0));
    vecs.push_back(mk("rr4", 4'hF, 4'h0, 4'h0, a, z, 4'b0001, 4'b1000, 1'b0, mv(3),    1'b0, BASE,         16'd0));
    vecs.push_back(mk("wr1", 4'b0010, 4'b0010, 4'h0, pk4(0, BASE + 32'h10, 0, 0), pk4(0, 32'hDEADBEEF, 0, 0),
                      4'b0010, 4'b0001, 1'b0, mv(0), 1'b1, BASE + 32'h10, 16'd0));
    vecs.push_back(mk("rd2", 4'b0100, 4'h0, 4'h0, pk4(0, 0, BASE + 32'h10, 0), z,
                      4'b0100, 4'b0010, 1'b0, 32'h0, 1'b0, BASE + 32'h10, 16'd0));
    vecs.push_back(mk("idle1", 4'h0, 4'h0, 4'h0, z, z, 4'b0000, 4'b0100, 1'b0, 32'hDEADBEEF, 1'b0, BASE, 16'd0));
    vecs.push_back(mk("ill_lo", 4'b1000, 4'h0, 4'h0, pk4(0, 0, 0, 32'h0FFF_FFFC), z,
                      4'b1000, 4'b0000, 1'b0, 32'h0, 1'b0, BASE, 16'd0));
    vecs.push_back(mk("ill_hi", 4'b0001, 4'b0001, 4'h0, pk4(32'h1010_0000, 0, 0, 0), pk4(32'h12345678, 0, 0, 0),
                      4'b0001, 4'b1000, 1'b1, 32'h0, 1'b0, BASE, 16'd1));
    vecs.push_back(mk("ill_al", 4'b0010, 4'h0, 4'h0, pk4(0, 32'h1000_0002, 0, 0), z,
                      4'b0010, 4'b0001, 1'b1, 32'h0, 1'b0, BASE, 16'd2));
    vecs.push_back(mk("idle2", 4'h0, 4'h0, 4'h0, z, z, 4'b0000, 4'b0010, 1'b1, 32'h0, 1'b0, BASE, 16'd3));
    vecs.push_back(mk("top_ok", 4'b0100, 4'h0, 4'h0, pk4(0, 0, 32'h100F_FFFC, 0), z,
                      4'b0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h100F_FFFC, 16'd3));
    vecs.push_back(mk("idle3", 4'h0, 4'h0, 4'h0, z, z, 4'b0000, 4'b0100, 1'b0, mv(255), 1'b0, BASE, 16'd3));
    vecs.push_back(mk("pre_lk", 4'b1000, 4'h0, 4'h0, a, z, 4'b1000, 4'b0000, 1'b0, 32'h0, 1'b0, BASE + 32'hC, 16'd3));
    vecs.push_back(mk("lock0", 4'hF, 4'h0, 4'b0001, a, z, 4'b0001, 4'b1000, 1'b0, mv(3), 1'b0, BASE, 16'd3));
    vecs.push_back(mk("lock1", 4'hF, 4'h0, 4'b0001, a, z, 4'b0001, 4'b0001, 1'b0, mv(0), 1'b0, BASE, 16'd3));
    vecs.push_back(mk("unlock", 4'hF, 4'h0, 4'b0000, a, z, 4'b0001, 4'b0001, 1'b0, mv(0), 1'b0, BASE, 16'd3));
    vecs.push_back(mk("after", 4'hF, 4'h0, 4'h0, a, z, 4'b0010, 4'b0001, 1'b0, mv(0), 1'b0, BASE + 32'h4, 16'd3));
    vecs.push_back(mk("idle4", 4'h0, 4'h0, 4'h0, z, z, 4'b0000, 4'b0010, 1'b0, mv(1), 1'b0, BASE, 16'd3));

    // Reset state with requests pending.
    repeat (2) @(negedge clk);
    drive(4'hF, 4'hF, 4'h0, a, z);
    #1;
    check_output("reset.ready",     32'(bus.req_ready), 32'h0);
    check_output("reset.mem_we",    32'(bus.mem_we),    32'h0);
    check_output("reset.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("reset.err_count", 32'(bus.err_count), 32'h0);
    drive(4'h0, 4'h0, 4'h0, z, z);
    rst_n = 1'b1;

    we_before = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].name == "ill_lo") we_before = we_pulses;
      apply_stimulus(vecs[i]);
      #1;
      check_vec(vecs[i]);
    end
    check_output("illegal.no_write", 32'(we_pulses - we_before), 32'h0);

    // Owner idle for 16 cycles releases the lock; requester 1 follows.
    step("tmo.lock", 4'b0001, 4'b0001, 4'b0001);
    for (int c = 1; c <= 16; c++) step($sformatf("tmo.wait%0d", c), 4'b1110, 4'b0000, 4'b0000);
    step("tmo.release", 4'b1110, 4'b0000, 4'b0010);

    // Owner returns exactly on the expiry cycle: it keeps the lock.
    step("tmo2.lock", 4'b0001, 4'b0001, 4'b0001);
    for (int c = 1; c <= 15; c++) step($sformatf("tmo2.wait%0d", c), 4'b1110, 4'b0000, 4'b0000);
    step("tmo2.owner_wins", 4'b1111, 4'b0001, 4'b0001);
    step("tmo2.still_locked", 4'b1110, 4'b0000, 4'b0000);
    step("tmo2.unlock", 4'b1111, 4'b0000, 4'b0001);
    step("tmo2.next_rr", 4'b1110, 4'b0000, 4'b0010);

    // Error counter saturation from a preset value.
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, z, z);
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    @(negedge clk);
    drive(4'b0100, 4'h0, 4'h0, pk4(0, 0, 32'h1000_0001, 0), z);
    #1;
    check_output("sat.ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);
    drive(4'b1000, 4'h0, 4'h0, pk4(0, 0, 0, 32'h0), z);
    #1;
    check_output("sat.count1", 32'(bus.err_count), 32'hFFFF);
    check_output("sat.rsp_err", 32'(bus.rsp_err), 32'h1);
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, z, z);
    #1;
    check_output("sat.count2", 32'(bus.err_count), 32'hFFFF);

    // Async reset in the middle of a granted write.
    drive(4'b0001, 4'b0001, 4'h0, pk4(BASE + 32'h20, 0, 0, 0), pk4(32'h55AA55AA, 0, 0, 0));
    #1;
    check_output("arst.pre_we", 32'(bus.mem_we), 32'h1);
    rst_n = 1'b0;
    #1;
    check_output("arst.mem_we",    32'(bus.mem_we),    32'h0);
    check_output("arst.ready",     32'(bus.req_ready), 32'h0);
    check_output("arst.rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("arst.rsp_err",   32'(bus.rsp_err),   32'h0);
    check_output("arst.err_count", 32'(bus.err_count), 32'h0);
    @(posedge clk);
    #1;
    check_output("arst.mem_kept",  mem[8],              mv(8));
    check_output("arst.rsp_rdata", bus.rsp_rdata,       32'h0);
    @(negedge clk);
    drive(4'hF, 4'h0, 4'h0, a, z);
    rst_n = 1'b1;
    #1;
    check_output("arst.first_grant", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    drive(4'h0, 4'h0, 4'h0, z, z);
    #1;
    check_output("arst.rsp_valid2", 32'(bus.rsp_valid), 32'b0001);
    check_output("arst.rsp_rdata2", bus.rsp_rdata,       mv(0));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Round-robin arbiter and sequencer that shares the single-port data memory between `NUM_REQ` requesters, such as the compute cores and the DMA/host port. It accepts at most one word access per cycle and drives the memory's write-enable, address and write-data inputs. It rejects illegal addresses before they reach the array and returns a registered one-cycle-latency response to the winning requester. An optional lock gives one requester exclusive back-to-back access for read-modify-write sequences.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: full byte-address width.
- `ADDR_REAL_WIDTH`, 20: log2 of the memory size in bytes (1 MB).
- `DATA_BASE`, 32'h10000000: byte address of memory offset 0.
- `LOCK_TIMEOUT`, 16: idle cycles after which a held lock is force-released.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: one-hot grant. Combinational; at most one bit is high.
- `req_we` in NUM_REQ: 1 = write, 0 = read.
- `req_lock` in NUM_REQ: request to keep the grant after this access.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed byte addresses; requester i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data, same packing.
- `rsp_valid` out NUM_REQ: one-cycle response pulse to the requester that was accepted.
- `rsp_rdata` out DATA_WIDTH: registered read data, shared by all requesters.
- `rsp_err` out 1: registered; high means the responded access was illegal.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory full address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_rdata` in DATA_WIDTH: memory combinational read data.
- `err_count` out 16: saturating count of illegal accesses.

## Operation
- **Handshake.** A request from requester i is accepted in a cycle where `req_valid[i] & req_ready[i]` is high. Requesters hold `req_we`, `req_addr`, `req_wdata` and `req_lock` stable while valid and not yet ready.
- **Arbitration.**
  - Round-robin search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
  - `last_grant` updates on every accept.
- **Lock.**
  - An accept with `req_lock=1` sets `locked=1` and `owner=i`.
  - While `locked`, only `owner` may be granted; all other requesters see ready=0.
  - An owner accept with `req_lock=0` clears `locked` after that access.
  - If `owner` holds `req_valid=0` for LOCK_TIMEOUT consecutive cycles, `locked` clears and arbitration resumes after `owner`.
- **Legality.** An address is legal iff all of:
  - `addr >= DATA_BASE`;
  - `addr - DATA_BASE <= 2**ADDR_REAL_WIDTH - 4`, computed unsigned in ADDR_WIDTH bits;
  - `addr[1:0] == 0`.
- **Memory drive during an accept cycle (all combinational from the winner).**
  - Legal access: `mem_addr=req_addr`, `mem_wdata=req_wdata`, `mem_we=req_we`.
  - Illegal access: `mem_addr=DATA_BASE`, `mem_we=0`. The array is never touched.
  - No accept: `mem_we=0`, `mem_addr=DATA_BASE`, `mem_wdata=0`.
  - `mem_we` is forced to 0 while `rst_n=0`.
- **Response (registered at the accept edge, valid the following cycle).**
  - `rsp_valid[i]=1` for exactly one cycle, for reads and writes alike.
  - `rsp_err` = illegal flag of the access.
  - `rsp_rdata` = `mem_rdata` for a legal read; 0 for writes and illegal accesses.
  - Responses have no backpressure.
- **Error counter.** `err_count` increments on each illegal accept and saturates at 16'hFFFF.

## Timing
- Latency: accept in cycle N gives the response in cycle N+1. A write becomes visible to a read accepted in cycle N+1.
- Throughput: one accept per cycle sustained. Back-to-back accepts from different requesters produce back-to-back responses.
- Reset (asynchronous, `rst_n=0`) sets all of the following:
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `err_count=0`;
  - `locked=0`, lock timeout counter = 0, `last_grant=NUM_REQ-1`;
  - `req_ready=0`, `mem_we=0`.
- Reset mid-operation: the in-flight response is dropped and the lock is lost. Requesters must reissue.
- Simultaneous events:
  - An owner accept with lock=0 while others are valid: the next grant goes round-robin from `owner+1` in the following cycle.
  - Timeout expiry and the owner raising valid in the same cycle: the owner's request wins and is granted; the timeout counter resets.

## Test plan
- **Round-robin:** all 4 requesters continuously valid reading 0x10000000/04/08/0C → grants in order 0,1,2,3,0; each rsp_valid arrives one cycle after its grant with the preloaded data.
- **Write-then-read:** req1 writes 0xDEADBEEF to 0x10000010, req2 reads 0x10000010 in the next cycle → req2's rsp_rdata = 0xDEADBEEF, rsp_err=0.
- **Illegal addresses:** accesses to 0x0FFFFFFC, 0x10100000 and 0x10000002 → rsp_err=1, rsp_rdata=0, mem_we never high, err_count=3; force err_count to 0xFFFF, issue one more illegal access → count stays 0xFFFF.
- **Lock:** req0 accepts with lock=1 while req1..3 are valid → only req0 is granted until its lock=0 access, then req1 is granted next.
- **Lock timeout:** req0 locks and then drops valid for 16 cycles → in cycle 17 req1 is granted.
- **Async reset:** assert `rst_n` low in the cycle a write is granted → mem_we=0 immediately, memory word unchanged, all outputs at reset values; after release, requester 0 wins first.
